// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if
//   Groups the fetch unit's ROM port and its execute-stage handshake.
//   Signal suffixes are given from the fetch unit's point of view.
//   rom_addr_o      ROM address (the PC)
//   rom_instr_i     ROM word for rom_addr_o, same cycle
//   instr_o         registered instruction issued to execute
//   valid_o         one-cycle pulse: instr_o is new
//   stall_i         execute busy, freezes fetch and issue
//   branch_taken_i  execute requests a PC redirect
//   branch_target_i redirect address
//   delay_busy_o    high while a delay-NOP is counting
//   instr_count_o   issued-instruction count (FETCH_INSTR_COUNT_EN only)
// modports: master = fetch unit, slave = ROM/execute side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0]  rom_addr_o;
  logic [INSTR_WIDTH-1:0] rom_instr_i;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic                   valid_o;
  logic                   stall_i;
  logic                   branch_taken_i;
  logic [ADDR_WIDTH-1:0]  branch_target_i;
  logic                   delay_busy_o;
`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0]            instr_count_o;

  modport master (
    output rom_addr_o, instr_o, valid_o, delay_busy_o, instr_count_o,
    input  rom_instr_i, stall_i, branch_taken_i, branch_target_i
  );
  modport slave (
    input  rom_addr_o, instr_o, valid_o, delay_busy_o, instr_count_o,
    output rom_instr_i, stall_i, branch_taken_i, branch_target_i
  );
`else
  modport master (
    output rom_addr_o, instr_o, valid_o, delay_busy_o,
    input  rom_instr_i, stall_i, branch_taken_i, branch_target_i
  );
  modport slave (
    input  rom_addr_o, instr_o, valid_o, delay_busy_o,
    output rom_instr_i, stall_i, branch_taken_i, branch_target_i
  );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   PC and fetch stage in front of the instruction ROM. Resolves JMP and
//   delay-NOP locally; every other opcode is issued to execute with a
//   one-cycle valid pulse.
//   clk_sys_i  system clock
//   rst_b_i    synchronous active-low reset
//   bus        instruction_fetch_unit_if.master (ROM + execute handshake)
//   Optional: define FETCH_INSTR_COUNT_EN to add bus.instr_count_o.
//
//   state    | meaning
//   ST_FETCH | decode the ROM word at the current PC
//   ST_DELAY | delay-NOP counting down, PC held

`ifndef NOP
`define NOP  4'h0
`endif
`ifndef LOAD
`define LOAD 4'h1
`endif
`ifndef STO
`define STO  4'h2
`endif
`ifndef ADD
`define ADD  4'h3
`endif
`ifndef SUB
`define SUB  4'h4
`endif
`ifndef MUL
`define MUL  4'h5
`endif
`ifndef LED
`define LED  4'h6
`endif
`ifndef JMP
`define JMP  4'hF
`endif

module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_b_i,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic {ST_FETCH, ST_DELAY} state_t;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = {`NOP, {(INSTR_WIDTH-4){1'b0}}};

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [23:0]            cnt_q, cnt_d;

  logic [3:0]             opcode;
  logic [23:0]            imm24;

  assign opcode = bus.rom_instr_i[INSTR_WIDTH-1 -: 4];
  assign imm24  = bus.rom_instr_i[23:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (bus.branch_taken_i) begin
      pc_d    = bus.branch_target_i;
      cnt_d   = '0;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!bus.stall_i) begin
            if (opcode == `JMP) begin
              pc_d = bus.rom_instr_i[ADDR_WIDTH-1:0];
            end else if (opcode == `NOP) begin
              if (imm24 == '0) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
              end else begin
                cnt_d   = imm24;
                state_d = ST_DELAY;
              end
            end else begin
              instr_d = bus.rom_instr_i;
              valid_d = 1'b1;
              pc_d    = pc_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DELAY: begin
          // The delay runs on wall-clock cycles, so stall is ignored here.
          // <= 1 also recovers if the counter were ever 0 in this state.
          if (cnt_q <= 24'd1) begin
            cnt_d   = '0;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = ST_FETCH;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_b_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_ADDR;
      instr_q <= INSTR_NOP;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rom_addr_o   = pc_q;
  assign bus.instr_o      = instr_q;
  assign bus.valid_o      = valid_q;
  assign bus.delay_busy_o = (state_q == ST_DELAY);

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] count_q;

  // Counts alongside the issue so it always equals the pulses seen so far.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_b_i) begin
      count_q <= '0;
    end else if (valid_d) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.instr_count_o = count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
`ifndef NOP
`define NOP  4'h0
`endif
`ifndef STO
`define STO  4'h2
`endif
`ifndef ADD
`define ADD  4'h3
`endif
`ifndef MUL
`define MUL  4'h5
`endif
`ifndef LED
`define LED  4'h6
`endif
`ifndef JMP
`define JMP  4'hF
`endif

module tb_instruction_fetch_unit;

  logic clk_sys_i = 1'b0;
  logic rst_b_i;

  instruction_fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(28)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(28),
    .RESET_ADDR (16'd0)
  ) u_dut (
    .clk_sys_i(clk_sys_i),
    .rst_b_i  (rst_b_i),
    .bus      (bus)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  logic [27:0] rom [0:65535];
  assign bus.rom_instr_i = rom[bus.rom_addr_o];

  localparam logic [27:0] W_STO1 = {`STO, 8'h11, 8'h01, 8'h02};
  localparam logic [27:0] W_STO2 = {`STO, 8'h22, 8'h03, 8'h04};
  localparam logic [27:0] W_MUL3 = {`MUL, 8'h33, 8'h05, 8'h06};
  localparam logic [27:0] W_MUL4 = {`MUL, 8'h44, 8'h07, 8'h08};
  localparam logic [27:0] W_MUL5 = {`MUL, 8'h55, 8'h09, 8'h0A};
  localparam logic [27:0] W_LED  = {`LED, 24'hABCDEF};
  localparam logic [27:0] W_ADD  = {`ADD, 8'h66, 8'h0B, 8'h0C};
  localparam logic [27:0] W_NOP0 = {`NOP, 24'd0};

  int n_tests = 0;
  int n_fail  = 0;
  int n_issued = 0;
  logic [27:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every issue must match the next queued expectation.
  always @(negedge clk_sys_i) begin
    if (bus.valid_o === 1'b1) begin
      n_issued++;
      if (exp_q.size() == 0) chk("unexpected_issue", {4'h0, bus.instr_o}, 32'hFFFF_FFFF);
      else                   chk("issue_word", {4'h0, bus.instr_o}, {4'h0, exp_q.pop_front()});
    end
  end

  task automatic cyc(input string tag, input logic [15:0] addr, input logic valid, input logic busy);
    @(negedge clk_sys_i);
    chk({tag, ".addr"},  {16'h0, bus.rom_addr_o}, {16'h0, addr});
    chk({tag, ".valid"}, {31'h0, bus.valid_o},    {31'h0, valid});
    chk({tag, ".busy"},  {31'h0, bus.delay_busy_o}, {31'h0, busy});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = '0;
    rom[0]       = {`NOP, 24'd4};
    rom[1]       = W_STO1;
    rom[2]       = W_STO2;
    rom[3]       = W_MUL3;
    rom[4]       = W_MUL4;
    rom[5]       = W_MUL5;
    rom[7]       = {`JMP, 8'd0, 16'd0};
    rom[8]       = {`JMP, 8'd0, 16'd9};
    rom[9]       = {`JMP, 8'd0, 16'd11};
    rom[11]      = W_ADD;
    rom[12]      = {`JMP, 8'd0, 16'd12};
    rom[16'h10]  = {`JMP, 8'd0, 16'hFFFF};
    rom[16'hFFFF] = W_LED;

    rst_b_i             = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = 16'd0;

    for (int i = 0; i < 3; i++) begin
      cyc("reset", 16'd0, 1'b0, 1'b0);
      chk("reset.instr", {4'h0, bus.instr_o}, {4'h0, W_NOP0});
    end
    rst_b_i = 1'b1;

    // Delay-NOP of 4 at address 0.
    for (int i = 0; i < 4; i++) cyc("delay4", 16'd0, 1'b0, 1'b1);
    cyc("delay_exit", 16'd1, 1'b0, 1'b0);

    // Back-to-back issue.
    exp_q.push_back(W_STO1);
    exp_q.push_back(W_STO2);
    exp_q.push_back(W_MUL3);
    cyc("issue1", 16'd2, 1'b1, 1'b0);
    cyc("issue2", 16'd3, 1'b1, 1'b0);
    cyc("issue3", 16'd4, 1'b1, 1'b0);

    // Stall with MUL at PC=4.
    bus.stall_i = 1'b1;
    for (int i = 0; i < 6; i++) cyc("stall", 16'd4, 1'b0, 1'b0);
    bus.stall_i = 1'b0;
    exp_q.push_back(W_MUL4);
    cyc("stall_release", 16'd5, 1'b1, 1'b0);

    // Branch during a stall wins; instruction register holds.
    bus.stall_i = 1'b1;
    cyc("stall2", 16'd5, 1'b0, 1'b0);
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 16'h0010;
    cyc("branch_in_stall", 16'h0010, 1'b0, 1'b0);
    chk("branch_instr_hold", {4'h0, bus.instr_o}, {4'h0, W_MUL4});
    bus.branch_taken_i = 1'b0;
    bus.stall_i        = 1'b0;

    // JMP to 0xFFFF, LED issues, PC wraps.
    cyc("jmp_top", 16'hFFFF, 1'b0, 1'b0);
    exp_q.push_back(W_LED);
    cyc("wrap", 16'h0000, 1'b1, 1'b0);

    // Redirect to JMP 0 at address 7, which re-enters the delay-NOP.
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 16'd7;
    cyc("br7", 16'd7, 1'b0, 1'b0);
    bus.branch_taken_i = 1'b0;
    cyc("jmp0", 16'd0, 1'b0, 1'b0);
    cyc("jmp0_delay", 16'd0, 1'b0, 1'b1);

    // Branch mid-DELAY aborts the count; back-to-back JMPs.
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 16'd8;
    cyc("br_in_delay", 16'd8, 1'b0, 1'b0);
    bus.branch_taken_i = 1'b0;
    cyc("jmp_a", 16'd9, 1'b0, 1'b0);
    cyc("jmp_b", 16'd11, 1'b0, 1'b0);
    exp_q.push_back(W_ADD);
    cyc("add_issue", 16'd12, 1'b1, 1'b0);
    cyc("self_jmp1", 16'd12, 1'b0, 1'b0);
    cyc("self_jmp2", 16'd12, 1'b0, 1'b0);

    // Delay counts through a stall.
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 16'd0;
    cyc("br0", 16'd0, 1'b0, 1'b0);
    bus.branch_taken_i = 1'b0;
    cyc("sdelay0", 16'd0, 1'b0, 1'b1);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc("sdelay", 16'd0, 1'b0, 1'b1);
    cyc("sdelay_exit", 16'd1, 1'b0, 1'b0);
    cyc("stall_after_delay", 16'd1, 1'b0, 1'b0);

    // Reset mid-DELAY overrides a concurrent branch.
    bus.stall_i         = 1'b0;
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 16'd0;
    cyc("br0b", 16'd0, 1'b0, 1'b0);
    bus.branch_taken_i = 1'b0;
    cyc("rdelay", 16'd0, 1'b0, 1'b1);
    chk("issued_total", n_issued, 32'd6);
`ifdef FETCH_INSTR_COUNT_EN
    chk("instr_count", bus.instr_count_o, 32'd6);
`endif
    rst_b_i             = 1'b0;
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 16'd5;
    cyc("reset_in_delay", 16'd0, 1'b0, 1'b0);
    chk("reset_in_delay.instr", {4'h0, bus.instr_o}, {4'h0, W_NOP0});
`ifdef FETCH_INSTR_COUNT_EN
    chk("instr_count_reset", bus.instr_count_o, 32'd0);
`endif
    rst_b_i            = 1'b1;
    bus.branch_taken_i = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
